// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: Mode encodings.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } usr_mode_e;

endpackage

// File: rtl/usr_frame_counter.sv
// Counts shifts within a WIDTH-shift frame and pulses done on the frame's last shift.
module usr_frame_counter #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    // Done is a single-cycle pulse; every non-wrapping cycle drops it.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (shift_i) begin
            if (count_q == CNT_W'(WIDTH - 1)) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / parallel load, with frame counting.
// Optional circular shifting via the Rotate port when USR_ROTATE_EN is defined.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [1:0]       Mode,
    input  logic             Sin_Left,
    input  logic             Sin_Right,
`ifdef USR_ROTATE_EN
    input  logic             Rotate,
`endif
    input  logic [WIDTH-1:0] Pin,
    output logic [WIDTH-1:0] Pout,
    output logic             Sout_Left,
    output logic             Sout_Right,
    output logic [CNT_W-1:0] Shift_Count,
    output logic             Frame_Done
);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             shift_c;
    logic             load_c;
    logic             rot_c;
    logic             ins_left_c;
    logic             ins_right_c;

`ifdef USR_ROTATE_EN
    assign rot_c = Rotate;
`else
    assign rot_c = 1'b0;
`endif

    // Serial inputs: either the external pins or the opposite end of the register.
    assign ins_left_c  = rot_c ? pout_q[0]       : Sin_Left;
    assign ins_right_c = rot_c ? pout_q[WIDTH-1] : Sin_Right;

    always_comb begin
        pout_d  = pout_q;
        shift_c = 1'b0;
        load_c  = 1'b0;
        if (Enable) begin
            case (usr_mode_e'(Mode))
                MODE_RIGHT: begin
                    pout_d  = {ins_left_c, pout_q[WIDTH-1:1]};
                    shift_c = 1'b1;
                end
                MODE_LEFT: begin
                    pout_d  = {pout_q[WIDTH-2:0], ins_right_c};
                    shift_c = 1'b1;
                end
                MODE_LOAD: begin
                    pout_d = Pin;
                    load_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pout_q <= '0;
        end else begin
            pout_q <= pout_d;
        end
    end

    usr_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clk     (Clock),
        .rst     (Reset),
        .shift_i (shift_c),
        .clear_i (load_c),
        .count_o (Shift_Count),
        .done_o  (Frame_Done)
    );

    assign Pout       = pout_q;
    assign Sout_Left  = pout_q[WIDTH-1];
    assign Sout_Right = pout_q[0];

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range >= 2).
REQ-002 SHALL have derived localparam CNT_W = $clog2(WIDTH), the shift-counter width.
REQ-003 SHALL have port Clock  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Enable  input  1  qualifies Mode; when low, all state holds.
REQ-006 SHALL have port Mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port Sin_Left  input  1  serial bit entering Pout[WIDTH-1] on shift right.
REQ-008 SHALL have port Sin_Right  input  1  serial bit entering Pout[0] on shift left.
REQ-009 SHALL have port Pin  input  WIDTH  parallel load data.
REQ-010 SHALL have port Pout  output  WIDTH  register contents.
REQ-011 SHALL have port Sout_Left  output  1  equal to Pout[WIDTH-1].
REQ-012 SHALL have port Sout_Right  output  1  equal to Pout[0].
REQ-013 SHALL have port Shift_Count  output  CNT_W  number of shifts taken in the current frame.
REQ-014 SHALL have port Frame_Done  output  1  one-cycle pulse marking the end of a WIDTH-shift frame.

Function
REQ-015 SHALL, on an edge with Enable=1 and Mode=01, load Pout <= {Sin_Left, Pout[WIDTH-1:1]}.
REQ-016 SHALL, on an edge with Enable=1 and Mode=10, load Pout <= {Pout[WIDTH-2:0], Sin_Right}.
REQ-017 SHALL, on an edge with Enable=1 and Mode=11, load Pout <= Pin and clear Shift_Count to 0.
REQ-018 SHALL hold Pout and Shift_Count when Mode=00 or Enable=0.
REQ-019 SHALL increment Shift_Count on every enabled shift of either direction; a direction change mid-frame does not restart the count.
REQ-020 SHALL wrap Shift_Count from WIDTH-1 to 0 on the WIDTH-th shift of a frame, and SHALL register Frame_Done=1 on that same edge.
REQ-021 SHALL drive Frame_Done high for exactly one cycle and low in every other cycle, including after loads, holds and stalls.
REQ-022 SHALL NOT assert Frame_Done when a parallel load occurs mid-frame; the frame restarts from count 0.
REQ-023 SHALL drive Sout_Left and Sout_Right combinationally from Pout, with zero added latency.

Reset
REQ-024 SHALL, on any edge with Reset=1, set Pout=0, Shift_Count=0 and Frame_Done=0, regardless of Enable, Mode or an in-progress frame.
REQ-025 SHALL give Reset priority over all other inputs; the first edge after Reset deasserts behaves as the start of a fresh frame.

Configuration
REQ-026 SHALL, when USR_ROTATE_EN is defined, add input port Rotate (1 bit); with Rotate=1, shifts are circular (shift right inserts Pout[0], shift left inserts Pout[WIDTH-1]), Sin_Left and Sin_Right are ignored, and Shift_Count/Frame_Done behave as for normal shifts.
REQ-027 SHALL, when USR_ROTATE_EN is undefined, have no Rotate port, and all shifts take their input from Sin_Left/Sin_Right.

Structure
REQ-028 SHALL place the Mode encodings (hold, right, left, load) as named constants in shared package usr_pkg.
REQ-029 SHALL implement the shift counter and Frame_Done generation in sub-module usr_frame_counter (inputs: shift strobe, clear; outputs: count, done).

Verification (WIDTH=8)
REQ-030 SHALL cover: Reset=1 over one edge with Enable=1, Mode=11, Pin=8'hFF -> Pout=8'h00, Shift_Count=0, Frame_Done=0.
REQ-031 SHALL cover: load 8'hA5, then one shift right with Sin_Left=1 -> Pout=8'hD2, Sout_Right=0, Shift_Count=1.
REQ-032 SHALL cover: after reset, 8 shifts left with Sin_Right=1,1,0,1,0,0,1,0 -> Pout=8'hD2, Shift_Count=0, Frame_Done high for exactly the one cycle after the 8th edge.
REQ-033 SHALL cover: 3 shifts, then Enable=0 for 2 cycles, then 5 shifts -> Shift_Count=3 throughout the stall, Frame_Done only after the 8th shift.
REQ-034 SHALL cover: 5 shifts, then load 8'h3C -> Pout=8'h3C, Shift_Count=0, no Frame_Done pulse; 8 further shifts -> one Frame_Done pulse.
REQ-035 SHALL cover, with USR_ROTATE_EN defined: load 8'h81, Rotate=1, one shift left -> Pout=8'h03; then one shift right -> Pout=8'h81.
